float_convert_seq: RTL and testbench
====================================

// Module: float_convert_seq
// PURPOSE
// Multi-cycle, parametrised FCVT unit. Converts float<->signed/unsigned int in all four cvt_type
// modes (W_H, WU_H, H_W, H_WU), honours RISC-V rounding modes and reports fflags. Uses an iterative
// 1-bit/cycle alignment shifter. Sits behind the FPU issue stage on a valid/ready handshake.
// PARAMETERS
// EXPONENT_WIDTH  5   float exponent bits; bias = 2**(EXPONENT_WIDTH-1)-1
// FRACTION_WIDTH  10  float stored-fraction bits; FLOAT_WIDTH = 1+EXPONENT_WIDTH+FRACTION_WIDTH
// INT_WIDTH       32  integer operand/result width (<= 32)
// PORTS
// CLK        in   1   clock, rising edge
// RST        in   1   asynchronous, active-high reset
// in_valid   in   1   operand valid
// in_ready   out  1   unit can accept; 1 only in IDLE
// in         in   32  int operand, or float in [FLOAT_WIDTH-1:0]
// cvt_type   in   fpu_cvt_type_t  FUNCT_W_H / FUNCT_WU_H / FUNCT_H_W / FUNCT_H_WU
// rm         in   3   rounding mode: RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4
// out_valid  out  1   result valid
// out_ready  in   1   consumer accepts result
// out        out  32  int result, or float NaN-boxed (upper bits all 1)
// flags      out  5   {NV,DZ,OF,UF,NX}; DZ and UF always 0
// BEHAVIOUR
// Reset: state=IDLE, out_valid=0, out=0, flags=0, in_ready=1. Reset mid-op aborts, no result emitted.
// FSM states: IDLE -> ALIGN -> ROUND -> HOLD -> IDLE.
// - IDLE: in_valid latches in, cvt_type and rm. Special cases go straight to HOLD with result next cycle.
// - ALIGN: one shift per cycle until shift count reaches 0.
// - ROUND: exactly 1 cycle.
// - HOLD: out_valid=1; out and flags held stable until out_ready=1, then IDLE.
//   No new accept is possible in the HOLD/out_ready cycle.
// Float->int (W_H, WU_H):
// - e = exp-bias; hidden bit = (exp!=0); subnormal uses e = 1-bias.
// - Magnitude register = {hidden, frac}.
//   - If e >= FRACTION_WIDTH, shift left by e-FRACTION_WIDTH.
//   - Otherwise shift right by FRACTION_WIDTH-e; shift count is clamped to FRACTION_WIDTH+2.
//   - Bits shifted out form guard g (first bit) and sticky s (OR of the rest).
// - Round increment, with l = result LSB:
//   - RNE: g&(l|s)
//   - RTZ: 0
//   - RDN: neg&(g|s)
//   - RUP: !neg&(g|s)
//   - RMM: g
//   - rm 5..7 is treated as RNE.
// - Signed (W_H): negate if sign.
//   - Rounded magnitude > 2**(INT_WIDTH-1)-1 (positive) or > 2**(INT_WIDTH-1) (negative): saturate to MAX/MIN, NV.
// - Unsigned (WU_H): negative with rounded magnitude != 0 -> 0, NV. Negative rounding to 0 -> 0, NX.
//   Overflow -> all ones, NV.
// - Special cases:
//   - NaN or +Inf -> MAX (signed 0x7FFFFFFF, unsigned all ones), NV.
//   - -Inf -> MIN (signed) or 0 (unsigned), NV.
//   - +/-0 -> 0, no flags.
// - NX = g|s when NV is clear; NV suppresses NX.
// Int->float (H_W, H_WU):
// - Magnitude = |in| (signed) or in (unsigned). Zero -> +0, no flags, fast path.
// - ALIGN shifts left until the MSB is set, counting lz (0..INT_WIDTH-1 cycles).
// - exp = bias+INT_WIDTH-1-lz.
// - frac = next FRACTION_WIDTH bits; guard = the following bit; sticky = OR of the remainder.
// - Rounding uses the same table as float->int. Mantissa carry-out increments exp.
// - Overflow when exp >= 2**EXPONENT_WIDTH-1 sets OF|NX:
//   - Result is Inf.
//   - Result is instead max finite for RTZ, for RDN with positive input, and for RUP with negative input.
// - NX = g|s.
// Unsupported cvt_type: out=0, flags=0, via HOLD.
// Latency = 1 (accept) + shift count + 1 (ROUND) cycles to out_valid. Special cases: 1 cycle.
// TESTING
// 1. W_H, in=0x4248 (3.140625), RNE -> out=3, flags=0x01. Then in=0x4100 (2.5): RNE -> 2, RMM -> 3, flags=0x01.
// 2. W_H, in=0xC100 (-2.5), RDN -> out=0xFFFFFFFD, flags=0x01.
//    WU_H, in=0xC000 -> 0, flags=0x10.
//    W_H, in=0x7E00 (NaN) -> 0x7FFFFFFF, flags=0x10.
// 3. H_W, in=1 -> out=0xFFFF3C00 after 31 ALIGN cycles.
//    H_W, in=-1 -> 0xFFFFBC00.
//    H_W, in=0 -> 0xFFFF0000, 1-cycle latency.
// 4. H_W, in=100000: RNE -> 0xFFFF7C00, flags=0x05; RTZ -> 0xFFFF7BFF, flags=0x05.
//    H_WU, in=2049: RNE -> 0xFFFF6800, flags=0x01.
// 5. Backpressure: out_ready=0 for 5 cycles -> out/flags stable, in_ready=0; in_valid ignored until return to IDLE.
// 6. RST pulsed during ALIGN -> out_valid=0 and in_ready=1 next cycle; next op completes correctly.

Source files
------------

// File: rtl/float_convert_seq.sv
// float_convert_seq: iterative float<->integer converter (FCVT).
// Aligns one bit per cycle, rounds per RISC-V rm and reports fflags.
package fpu_cvt_pkg;
   typedef enum logic [2:0] {
      FUNCT_W_H  = 3'd0,
      FUNCT_WU_H = 3'd1,
      FUNCT_H_W  = 3'd2,
      FUNCT_H_WU = 3'd3
   } fpu_cvt_type_t;
endpackage

module float_convert_seq
   import fpu_cvt_pkg::*;
#(
   parameter int EXPONENT_WIDTH = 5,
   parameter int FRACTION_WIDTH = 10,
   parameter int INT_WIDTH      = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in,
   input  fpu_cvt_type_t cvt_type,
   input  logic [2:0]    rm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out,
   output logic [4:0]    flags
);
   localparam int EW   = EXPONENT_WIDTH;
   localparam int FW   = FRACTION_WIDTH;
   localparam int IW   = INT_WIDTH;
   localparam int FLW  = 1 + EW + FW;
   localparam int BIAS = 2**(EW-1) - 1;
   localparam int EMAX = 2**EW - 1;
   localparam int CW   = 8;
   localparam int XW   = 16;

   localparam logic signed [XW-1:0] IW_S  = XW'(IW);
   localparam logic signed [XW-1:0] FW_S  = XW'(FW);
   localparam logic signed [XW-1:0] RCL_S = XW'(FW + 2);

   localparam logic [IW:0] LIM_POS = {2'b00, {(IW-1){1'b1}}};
   localparam logic [IW:0] LIM_NEG = {2'b01, {(IW-1){1'b0}}};
   localparam logic [31-FLW:0] BOX = '1;

   typedef enum logic [1:0] {IDLE, ALIGN, ROUND, HOLD} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        mag_q, mag_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 guard_q, guard_d;
   logic                 sticky_q, sticky_d;
   logic                 neg_q, neg_d;
   logic                 left_q, left_d;
   fpu_cvt_type_t        cvt_q, cvt_d;
   logic [2:0]           rm_q, rm_d;
   logic [31:0]          out_q, out_d;
   logic [4:0]           flags_q, flags_d;

   function automatic logic rnd_inc(
      input logic [2:0] m,
      input logic       ng,
      input logic       l,
      input logic       g,
      input logic       s
   );
      case (m)
         3'd1:    rnd_inc = 1'b0;
         3'd2:    rnd_inc = ng & (g | s);
         3'd3:    rnd_inc = ~ng & (g | s);
         3'd4:    rnd_inc = g;
         default: rnd_inc = g & (l | s);
      endcase
   endfunction

   // operand decode for the accept cycle
   logic                 in_sign;
   logic [EW-1:0]        in_exp;
   logic [FW-1:0]        in_frac;
   logic                 in_is_nan;
   logic [XW-1:0]        eff_exp;
   logic signed [XW-1:0] e_unb;
   logic signed [XW-1:0] rsh;
   logic [IW-1:0]        sat_val;
   logic [IW-1:0]        int_op;
   logic                 int_neg;
   logic [IW-1:0]        int_abs;

   assign in_sign   = in[FLW-1];
   assign in_exp    = in[FLW-2 -: EW];
   assign in_frac   = in[FW-1:0];
   assign in_is_nan = (in_exp == '1) && (in_frac != '0);
   assign eff_exp   = (in_exp == '0) ? XW'(1) : XW'(in_exp);
   assign e_unb     = $signed(eff_exp) - $signed(XW'(BIAS));
   assign rsh       = FW_S - e_unb;
   assign int_op    = in[IW-1:0];
   assign int_neg   = (cvt_type == FUNCT_H_W) & int_op[IW-1];
   assign int_abs   = int_neg ? (~int_op + 1'b1) : int_op;

   // saturation value for NaN/Inf/out-of-range operands
   always_comb begin
      sat_val = '0;
      if (cvt_type == FUNCT_W_H) begin
         if (in_is_nan || !in_sign) sat_val = {1'b0, {(IW-1){1'b1}}};
         else sat_val = {1'b1, {(IW-1){1'b0}}};
      end else if (in_is_nan || !in_sign) begin
         sat_val = '1;
      end
   end

   // float->int rounding of the aligned magnitude
   logic          f_inc;
   logic [IW:0]   rnd_mag;
   logic [IW-1:0] neg_mag;
   assign f_inc   = rnd_inc(rm_q, neg_q, mag_q[0], guard_q, sticky_q);
   assign rnd_mag = {1'b0, mag_q} + (IW+1)'(f_inc);
   assign neg_mag = ~rnd_mag[IW-1:0] + 1'b1;

   // int->float rounding of the normalised magnitude
   logic [FW-1:0]  i_frac;
   logic           i_g;
   logic           i_s;
   logic           i_inc;
   logic [FW+1:0]  i_mant;
   logic [XW-1:0]  i_exp;
   logic           i_sat_max;
   logic [FLW-1:0] i_res;
   logic [FLW-1:0] i_inf;
   logic [FLW-1:0] i_max;
   assign i_frac = mag_q[IW-2 -: FW];
   assign i_g    = mag_q[IW-2-FW];
   assign i_s    = |mag_q[IW-3-FW:0];
   assign i_inc  = rnd_inc(rm_q, neg_q, i_frac[0], i_g, i_s);
   assign i_mant = {2'b01, i_frac} + (FW+2)'(i_inc);
   assign i_exp  = XW'(BIAS + IW - 1) - XW'(cnt_q)
                 + XW'(i_mant[FW+1]);
   assign i_sat_max = (rm_q == 3'd1)
                    | ((rm_q == 3'd2) & ~neg_q)
                    | ((rm_q == 3'd3) & neg_q);
   assign i_res = {neg_q, i_exp[EW-1:0], i_mant[FW-1:0]};
   assign i_inf = {neg_q, {EW{1'b1}}, {FW{1'b0}}};
   assign i_max = {neg_q, EW'(EMAX - 1), {FW{1'b1}}};

   // next-state, datapath and result computation
   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      neg_d    = neg_q;
      left_d   = left_q;
      cvt_d    = cvt_q;
      rm_d     = rm_q;
      out_d    = out_q;
      flags_d  = flags_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               cvt_d    = cvt_type;
               rm_d     = rm;
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               cnt_d    = '0;
               left_d   = 1'b1;
               unique case (cvt_type)
                  FUNCT_W_H, FUNCT_WU_H: begin
                     neg_d = in_sign;
                     mag_d = IW'({in_exp != '0, in_frac});
                     if (in_exp == '1 || e_unb >= IW_S) begin
                        state_d = HOLD;
                        out_d   = 32'(sat_val);
                        flags_d = 5'b10000;
                     end else if (in_exp == '0 && in_frac == '0) begin
                        state_d = HOLD;
                        out_d   = '0;
                        flags_d = '0;
                     end else if (e_unb >= FW_S) begin
                        cnt_d   = CW'(e_unb - FW_S);
                        state_d = (e_unb == FW_S) ? ROUND : ALIGN;
                     end else begin
                        left_d  = 1'b0;
                        cnt_d   = (rsh > RCL_S) ? CW'(FW + 2) : CW'(rsh);
                        state_d = ALIGN;
                     end
                  end
                  FUNCT_H_W, FUNCT_H_WU: begin
                     neg_d = int_neg;
                     mag_d = int_abs;
                     if (int_abs == '0) begin
                        state_d = HOLD;
                        out_d   = {BOX, {FLW{1'b0}}};
                        flags_d = '0;
                     end else begin
                        state_d = int_abs[IW-1] ? ROUND : ALIGN;
                     end
                  end
                  default: begin
                     state_d = HOLD;
                     out_d   = '0;
                     flags_d = '0;
                  end
               endcase
            end
         end
         ALIGN: begin
            if (cvt_q == FUNCT_H_W || cvt_q == FUNCT_H_WU) begin
               mag_d = mag_q << 1;
               cnt_d = cnt_q + 1'b1;
               if (mag_q[IW-2]) state_d = ROUND;
            end else if (left_q) begin
               mag_d = mag_q << 1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = ROUND;
            end else begin
               mag_d    = mag_q >> 1;
               guard_d  = mag_q[0];
               sticky_d = sticky_q | guard_q;
               cnt_d    = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = ROUND;
            end
         end
         ROUND: begin
            state_d = HOLD;
            flags_d = '0;
            out_d   = '0;
            if (cvt_q == FUNCT_H_W || cvt_q == FUNCT_H_WU) begin
               if (i_exp >= XW'(EMAX)) begin
                  out_d   = {BOX, i_sat_max ? i_max : i_inf};
                  flags_d = 5'b00101;
               end else begin
                  out_d   = {BOX, i_res};
                  flags_d = {4'b0000, i_g | i_s};
               end
            end else if (cvt_q == FUNCT_W_H) begin
               if (neg_q ? (rnd_mag > LIM_NEG) : (rnd_mag > LIM_POS)) begin
                  out_d   = neg_q ? 32'(LIM_NEG[IW-1:0])
                                  : 32'(LIM_POS[IW-1:0]);
                  flags_d = 5'b10000;
               end else begin
                  out_d   = 32'(neg_q ? neg_mag : rnd_mag[IW-1:0]);
                  flags_d = {4'b0000, guard_q | sticky_q};
               end
            end else begin
               if (neg_q) begin
                  flags_d = (rnd_mag != '0) ? 5'b10000
                          : {4'b0000, guard_q | sticky_q};
               end else if (rnd_mag[IW]) begin
                  out_d   = 32'({IW{1'b1}});
                  flags_d = 5'b10000;
               end else begin
                  out_d   = 32'(rnd_mag[IW-1:0]);
                  flags_d = {4'b0000, guard_q | sticky_q};
               end
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         cnt_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         neg_q    <= 1'b0;
         left_q   <= 1'b0;
         cvt_q    <= FUNCT_W_H;
         rm_q     <= '0;
         out_q    <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         neg_q    <= neg_d;
         left_q   <= left_d;
         cvt_q    <= cvt_d;
         rm_q     <= rm_d;
         out_q    <= out_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign out       = out_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_float_convert_seq.sv
// tb_float_convert_seq: directed checks for float_convert_seq.
// Each scenario task drives vectors and compares to hand values.
module tb_float_convert_seq;
   import fpu_cvt_pkg::*;

   logic          CLK;
   logic          RST;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_d;
   fpu_cvt_type_t cvt_type;
   logic [2:0]    rm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out;
   logic [4:0]    flags;

   int checks;
   int errors;

   float_convert_seq dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_d),
      .cvt_type  (cvt_type),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flags     (flags)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // drive one op from IDLE, wait (bounded) for the result, then accept it
   task automatic run_op(
      input  fpu_cvt_type_t t,
      input  logic [31:0]   v,
      input  logic [2:0]    m,
      output logic [31:0]   o,
      output logic [4:0]    f,
      output int            lat
   );
      bit got;
      cvt_type = t;
      in_d     = v;
      rm       = m;
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(posedge CLK); #1;
         lat++;
      end
      if (got) begin
         o = out;
         f = flags;
      end else begin
         o = 'x;
         f = 'x;
         lat = -1;
      end
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      checks++; if (out !== 32'h0) begin errors++; $display("FAIL rst_out: got %h want 0", out); end
      checks++; if (flags !== 5'h0) begin errors++; $display("FAIL rst_flags: got %h want 0", flags); end
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_f2i_round();
      logic [31:0] o; logic [4:0] f; int lat;
      run_op(FUNCT_W_H, 32'h4248, 3'd0, o, f, lat);
      checks++; if (o !== 32'd3) begin errors++; $display("FAIL pi_rne out: got %h want 3", o); end
      checks++; if (f !== 5'h01) begin errors++; $display("FAIL pi_rne flags: got %h want 01", f); end
      checks++; if (lat !== 11) begin errors++; $display("FAIL pi_rne latency: got %0d want 11", lat); end
      run_op(FUNCT_W_H, 32'h4100, 3'd0, o, f, lat);
      checks++; if (o !== 32'd2) begin errors++; $display("FAIL 2p5_rne out: got %h want 2", o); end
      checks++; if (f !== 5'h01) begin errors++; $display("FAIL 2p5_rne flags: got %h want 01", f); end
      run_op(FUNCT_W_H, 32'h4100, 3'd4, o, f, lat);
      checks++; if (o !== 32'd3) begin errors++; $display("FAIL 2p5_rmm out: got %h want 3", o); end
      checks++; if (f !== 5'h01) begin errors++; $display("FAIL 2p5_rmm flags: got %h want 01", f); end
      run_op(FUNCT_W_H, 32'h4100, 3'd7, o, f, lat);
      checks++; if (o !== 32'd2) begin errors++; $display("FAIL 2p5_rm7 out: got %h want 2", o); end
      run_op(FUNCT_W_H, 32'hC100, 3'd2, o, f, lat);
      checks++; if (o !== 32'hFFFFFFFD) begin errors++; $display("FAIL m2p5_rdn out: got %h want fffffffd", o); end
      checks++; if (f !== 5'h01) begin errors++; $display("FAIL m2p5_rdn flags: got %h want 01", f); end
      run_op(FUNCT_W_H, 32'h7BFF, 3'd0, o, f, lat);
      checks++; if (o !== 32'd65504) begin errors++; $display("FAIL maxhalf out: got %h want 0000ffe0", o); end
      checks++; if (f !== 5'h00) begin errors++; $display("FAIL maxhalf flags: got %h want 00", f); end
   endtask

   task automatic test_f2i_special();
      logic [31:0] o; logic [4:0] f; int lat;
      run_op(FUNCT_WU_H, 32'hC000, 3'd0, o, f, lat);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL wu_m2 out: got %h want 0", o); end
      checks++; if (f !== 5'h10) begin errors++; $display("FAIL wu_m2 flags: got %h want 10", f); end
      run_op(FUNCT_WU_H, 32'hB800, 3'd0, o, f, lat);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL wu_mhalf out: got %h want 0", o); end
      checks++; if (f !== 5'h01) begin errors++; $display("FAIL wu_mhalf flags: got %h want 01", f); end
      run_op(FUNCT_W_H, 32'h7E00, 3'd0, o, f, lat);
      checks++; if (o !== 32'h7FFFFFFF) begin errors++; $display("FAIL nan out: got %h want 7fffffff", o); end
      checks++; if (f !== 5'h10) begin errors++; $display("FAIL nan flags: got %h want 10", f); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL nan latency: got %0d want 1", lat); end
      run_op(FUNCT_W_H, 32'hFC00, 3'd0, o, f, lat);
      checks++; if (o !== 32'h80000000) begin errors++; $display("FAIL minf out: got %h want 80000000", o); end
      checks++; if (f !== 5'h10) begin errors++; $display("FAIL minf flags: got %h want 10", f); end
      run_op(FUNCT_WU_H, 32'h7C00, 3'd0, o, f, lat);
      checks++; if (o !== 32'hFFFFFFFF) begin errors++; $display("FAIL wu_pinf out: got %h want ffffffff", o); end
      run_op(FUNCT_W_H, 32'h8000, 3'd0, o, f, lat);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL mzero out: got %h want 0", o); end
      checks++; if (f !== 5'h00) begin errors++; $display("FAIL mzero flags: got %h want 00", f); end
   endtask

   task automatic test_i2f();
      logic [31:0] o; logic [4:0] f; int lat;
      run_op(FUNCT_H_W, 32'd1, 3'd0, o, f, lat);
      checks++; if (o !== 32'hFFFF3C00) begin errors++; $display("FAIL hw_1 out: got %h want ffff3c00", o); end
      checks++; if (f !== 5'h00) begin errors++; $display("FAIL hw_1 flags: got %h want 00", f); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL hw_1 latency: got %0d want 33", lat); end
      run_op(FUNCT_H_W, 32'hFFFFFFFF, 3'd0, o, f, lat);
      checks++; if (o !== 32'hFFFFBC00) begin errors++; $display("FAIL hw_m1 out: got %h want ffffbc00", o); end
      run_op(FUNCT_H_W, 32'd0, 3'd0, o, f, lat);
      checks++; if (o !== 32'hFFFF0000) begin errors++; $display("FAIL hw_0 out: got %h want ffff0000", o); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL hw_0 latency: got %0d want 1", lat); end
      run_op(FUNCT_H_WU, 32'd2049, 3'd0, o, f, lat);
      checks++; if (o !== 32'hFFFF6800) begin errors++; $display("FAIL hwu_2049 out: got %h want ffff6800", o); end
      checks++; if (f !== 5'h01) begin errors++; $display("FAIL hwu_2049 flags: got %h want 01", f); end
      run_op(FUNCT_H_WU, 32'd2049, 3'd3, o, f, lat);
      checks++; if (o !== 32'hFFFF6801) begin errors++; $display("FAIL hwu_2049_rup out: got %h want ffff6801", o); end
   endtask

   task automatic test_i2f_overflow();
      logic [31:0] o; logic [4:0] f; int lat;
      run_op(FUNCT_H_W, 32'd100000, 3'd0, o, f, lat);
      checks++; if (o !== 32'hFFFF7C00) begin errors++; $display("FAIL ovf_rne out: got %h want ffff7c00", o); end
      checks++; if (f !== 5'h05) begin errors++; $display("FAIL ovf_rne flags: got %h want 05", f); end
      run_op(FUNCT_H_W, 32'd100000, 3'd1, o, f, lat);
      checks++; if (o !== 32'hFFFF7BFF) begin errors++; $display("FAIL ovf_rtz out: got %h want ffff7bff", o); end
      checks++; if (f !== 5'h05) begin errors++; $display("FAIL ovf_rtz flags: got %h want 05", f); end
      run_op(FUNCT_H_W, 32'h80000000, 3'd3, o, f, lat);
      checks++; if (o !== 32'hFFFFFBFF) begin errors++; $display("FAIL min_rup out: got %h want fffffbff", o); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL min_rup latency: got %0d want 2", lat); end
      run_op(FUNCT_H_W, 32'h80000000, 3'd2, o, f, lat);
      checks++; if (o !== 32'hFFFFFC00) begin errors++; $display("FAIL min_rdn out: got %h want fffffc00", o); end
   endtask

   task automatic test_backpressure();
      bit got;
      cvt_type = FUNCT_W_H;
      in_d     = 32'h4100;
      rm       = 3'd4;
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(posedge CLK); #1;
      end
      checks++; if (!got) begin errors++; $display("FAIL bp_wait: got no out_valid want out_valid=1"); end
      cvt_type = FUNCT_H_W;
      in_d     = 32'd5;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         checks++;
         if (out !== 32'd3 || flags !== 5'h01 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got out=%h flags=%h ov=%b ir=%b want 3/01/1/0", i, out, flags, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got ir=%b ov=%b want 1/0", in_ready, out_valid);
      end
      @(posedge CLK); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_idle: got ir=%b ov=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] o; logic [4:0] f; int lat;
      cvt_type = FUNCT_H_W;
      in_d     = 32'd1;
      rm       = 3'd0;
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(posedge CLK); #1;
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_busy: got in_ready=%b want 0", in_ready); end
      RST = 1'b1;
      #2;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst: got ov=%b ir=%b want 0/1", out_valid, in_ready);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_result: got ov=%b want 0", out_valid); end
      run_op(FUNCT_H_W, 32'hFFFFFFFF, 3'd0, o, f, lat);
      checks++; if (o !== 32'hFFFFBC00) begin errors++; $display("FAIL mid_next out: got %h want ffffbc00", o); end
      checks++; if (f !== 5'h00) begin errors++; $display("FAIL mid_next flags: got %h want 00", f); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      RST       = 1'b1;
      in_valid  = 1'b0;
      in_d      = '0;
      cvt_type  = FUNCT_W_H;
      rm        = 3'd0;
      out_ready = 1'b0;
      test_reset();
      test_f2i_round();
      test_f2i_special();
      test_i2f();
      test_i2f_overflow();
      test_backpressure();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
